// File: rtl/fpa_seq_if.sv
// Handshake bundle between the EX/WB pipeline and the FP add/sub sequencer.
// master = pipeline side, slave = sequencer.
interface fpa_seq_if #(
    parameter int W    = 32,
    parameter int RD_W = 5
);
    logic            issue_valid;
    logic            issue_sub;
    logic [RD_W-1:0] issue_rd;
    logic            flush;
    logic            fpa_start;
    logic            fpa_sub;
    logic [W-1:0]    fpa_result;
    logic            wb_int_valid;
    logic            stall;
    logic            ex_bubble;
    logic            wb_sel;
    logic            wb_fp_we;
    logic [RD_W-1:0] wb_fp_rd;
    logic [W-1:0]    wb_fp_data;

    modport master (
        output issue_valid, issue_sub, issue_rd, flush, fpa_result, wb_int_valid,
        input  fpa_start, fpa_sub, stall, ex_bubble, wb_sel, wb_fp_we, wb_fp_rd, wb_fp_data
    );

    modport slave (
        input  issue_valid, issue_sub, issue_rd, flush, fpa_result, wb_int_valid,
        output fpa_start, fpa_sub, stall, ex_bubble, wb_sel, wb_fp_we, wb_fp_rd, wb_fp_data
    );
endinterface

// File: rtl/fpa_seq_ctrl.sv
// Launches the shared FP add/sub unit from EX, stalls the front end for its latency,
// and arbitrates the single register-file write port (integer writeback always wins).
module fpa_seq_ctrl #(
    parameter int LAT  = 3,
    parameter int W    = 32,
    parameter int RD_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    fpa_seq_if.slave bus
);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WB
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [RD_W-1:0] r_rd;
    logic [W-1:0]    r_result;

    logic w_start;
    logic w_sub;
    logic w_stall;
    logic w_bubble;
    logic w_sel;
    logic w_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_rd  <= bus.issue_rd;
                r_cnt <= CNT_LOAD;
            end
            // Counter only runs while the op is live; a flushed op leaves it untouched.
            if (r_state == S_BUSY && !bus.flush) begin
                if (r_cnt == '0) begin
                    r_result <= bus.fpa_result;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_sub       = 1'b0;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_sel       = 1'b0;
        w_we        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.issue_valid && !bus.flush) begin
                    w_start     = 1'b1;
                    w_sub       = bus.issue_sub;
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                // Flush beats the pending write; older integer writeback beats the FP write.
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.wb_int_valid) begin
                    w_stall = 1'b1;
                end else begin
                    w_sel       = 1'b1;
                    w_we        = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.fpa_start  = w_start;
    assign bus.fpa_sub    = w_sub;
    assign bus.stall      = w_stall;
    assign bus.ex_bubble  = w_bubble;
    assign bus.wb_sel     = w_sel;
    assign bus.wb_fp_we   = w_we;
    assign bus.wb_fp_rd   = w_we ? r_rd : '0;
    assign bus.wb_fp_data = w_we ? r_result : '0;
endmodule
